// File: rtl/sram_arbiter.sv
// Two-port arbiter and fixed-timing access sequencer for a 16-bit asynchronous SRAM.
// Optional SRAM_ARB_FIXED_PRIO_EN: port A always wins ties (default build is round-robin).
module sram_arbiter #(
  parameter int ADDR_W        = 17,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [15:0]       a_wdata,
  input  logic [1:0]        a_be,
  output logic              a_ack,
  output logic [15:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [15:0]       b_wdata,
  input  logic [1:0]        b_be,
  output logic              b_ack,
  output logic [15:0]       b_rdata,
  output logic [ADDR_W-1:0] sram_a,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
  output logic              busy
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  logic              last_grant;  // 1 = port B
  logic              grant;       // 1 = port B
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [15:0]       lat_wdata;
  logic [1:0]        lat_be;
  logic [CNT_W-1:0]  cnt;

  logic              any_req;
  logic              pick_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [15:0]       sel_wdata;
  logic [1:0]        sel_be;

  // Arbitration between ports and selection of the winning request fields
  always_comb begin
    any_req = a_req | b_req;
    if (a_req && b_req) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      pick_b = 1'b0;
`else
      pick_b = ~last_grant;
`endif
    end else begin
      pick_b = b_req;
    end
    if (pick_b) begin
      sel_we    = b_we;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
      sel_be    = b_be;
    end else begin
      sel_we    = a_we;
      sel_addr  = a_addr;
      sel_wdata = a_wdata;
      sel_be    = a_be;
    end
  end

  // Sequencer FSM with all pin strobes, acks and read data registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant       <= 1'b0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= 16'h0000;
      lat_be      <= 2'b00;
      cnt         <= '0;
      sram_a      <= '0;
      sram_dq_out <= 16'h0000;
      sram_dq_oe  <= 1'b0;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_ub_n   <= 1'b1;
      sram_lb_n   <= 1'b1;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= 16'h0000;
      b_rdata     <= 16'h0000;
      busy        <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= ACCESS;
            busy       <= 1'b1;
            grant      <= pick_b;
            last_grant <= pick_b;
            lat_we     <= sel_we;
            lat_addr   <= sel_addr;
            lat_wdata  <= sel_wdata;
            lat_be     <= sel_be;
            cnt        <= CNT_LOAD;
            sram_a     <= sel_addr;
            sram_ub_n  <= ~sel_be[1];
            sram_lb_n  <= ~sel_be[0];
            if (sel_we) begin
              sram_we_n   <= 1'b0;
              sram_oe_n   <= 1'b1;
              sram_dq_oe  <= 1'b1;
              sram_dq_out <= sel_wdata;
            end else begin
              sram_we_n  <= 1'b1;
              sram_oe_n  <= 1'b0;
              sram_dq_oe <= 1'b0;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            // Last strobe cycle: sample the pads on this edge, then turn the bus around
            state      <= DONE;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (grant) begin
              b_ack <= 1'b1;
              if (!lat_we) begin
                b_rdata <= sram_dq_in;
              end else begin
                b_rdata <= b_rdata;
              end
            end else begin
              a_ack <= 1'b1;
              if (!lat_we) begin
                a_rdata <= sram_dq_in;
              end else begin
                a_rdata <= a_rdata;
              end
            end
          end else begin
            cnt       <= cnt - CNT_W'(1);
            sram_a    <= lat_addr;
            sram_ub_n <= ~lat_be[1];
            sram_lb_n <= ~lat_be[0];
            if (lat_we) begin
              sram_we_n   <= 1'b0;
              sram_oe_n   <= 1'b1;
              sram_dq_oe  <= 1'b1;
              sram_dq_out <= lat_wdata;
            end else begin
              sram_we_n  <= 1'b1;
              sram_oe_n  <= 1'b0;
              sram_dq_oe <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_ub_n  <= 1'b1;
          sram_lb_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a 2-cycle instance with an SRAM model and a 1-cycle instance.
module tb_sram_arbiter;

  logic        clock;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [16:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic [1:0]  a_be, b_be;
  logic        a_ack, b_ack;
  logic [16:0] sram_a;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, busy;

  logic        p_a_req, p_a_ack, p_b_ack, p_oe_n, p_we_n, p_ub_n, p_lb_n, p_dq_oe, p_busy;
  logic [16:0] p_a_addr, p_sram_a;
  logic [15:0] p_a_rdata, p_b_rdata, p_dq_out, p_dq_in;
  logic        p_zero1;
  logic [16:0] p_zero_addr;
  logic [15:0] p_zero16;
  logic [1:0]  p_be;

  logic [15:0] mem [0:1023];
  int nvec = 0;
  int nmis = 0;

  sram_arbiter #(.ADDR_W(17), .ACCESS_CYCLES(2)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .sram_a(sram_a), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .busy(busy)
  );

  sram_arbiter #(.ADDR_W(17), .ACCESS_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset),
    .a_req(p_a_req), .a_we(p_zero1), .a_addr(p_a_addr), .a_wdata(p_zero16), .a_be(p_be),
    .a_ack(p_a_ack), .a_rdata(p_a_rdata),
    .b_req(p_zero1), .b_we(p_zero1), .b_addr(p_zero_addr), .b_wdata(p_zero16), .b_be(p_be),
    .b_ack(p_b_ack), .b_rdata(p_b_rdata),
    .sram_a(p_sram_a), .sram_dq_out(p_dq_out), .sram_dq_oe(p_dq_oe),
    .sram_dq_in(p_dq_in), .sram_oe_n(p_oe_n), .sram_we_n(p_we_n),
    .sram_ub_n(p_ub_n), .sram_lb_n(p_lb_n), .busy(p_busy)
  );

  always #5 clock = ~clock;

  // Asynchronous SRAM model: byte-lane writes while we_n is low, read data while oe_n is low
  always @(posedge clock) begin
    if (!sram_we_n && sram_dq_oe) begin
      if (!sram_ub_n) mem[sram_a[9:0]][15:8] <= sram_dq_out[15:8];
      if (!sram_lb_n) mem[sram_a[9:0]][7:0]  <= sram_dq_out[7:0];
    end
  end
  assign sram_dq_in = (!sram_oe_n) ? mem[sram_a[9:0]] : 16'h0000;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    clock = 1'b0; reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = 17'h0; a_wdata = 16'h0; a_be = 2'b11;
    b_req = 1'b0; b_we = 1'b0; b_addr = 17'h0; b_wdata = 16'h0; b_be = 2'b11;
    p_a_req = 1'b0; p_a_addr = 17'h00033; p_zero1 = 1'b0; p_zero_addr = 17'h0;
    p_zero16 = 16'h0; p_be = 2'b11; p_dq_in = 16'h5A5A;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[10'h020] = 16'hAAAA;
    tick(); tick();
    chk("rst_strobes", {28'h0, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'hF);
    chk("rst_misc", {27'h0, sram_dq_oe, a_ack, b_ack, busy, 1'b0}, 32'h0);
    chk("rst_bus", {sram_a, sram_dq_out[14:0]}, 32'h0);
    chk("rst_rdata", {a_rdata, b_rdata}, 32'h0);
    reset = 1'b0;
    tick();

    // 1: A write 0x00010 <- 0xBEEF, then read it back
    a_req = 1'b1; a_we = 1'b1; a_addr = 17'h00010; a_wdata = 16'hBEEF; a_be = 2'b11;
    tick();
    chk("wr_c1_pins", {sram_we_n, sram_oe_n, sram_dq_oe, a_ack, busy}, {1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
    chk("wr_c1_bus", {sram_a[15:0], sram_dq_out}, {16'h0010, 16'hBEEF});
    chk("wr_c1_lanes", {sram_ub_n, sram_lb_n}, 2'b00);
    tick();
    chk("wr_c2_pins", {sram_we_n, sram_dq_oe, a_ack}, {1'b0, 1'b1, 1'b0});
    tick();
    chk("wr_c3_ack", {sram_we_n, sram_dq_oe, a_ack, b_ack, busy}, {1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    chk("wr_c3_addr_hold", sram_a, 32'h10);
    a_req = 1'b0;
    tick();
    chk("wr_c4_idle", {a_ack, busy}, 2'b00);
    a_req = 1'b1; a_we = 1'b0;
    tick();
    chk("rd_c1_pins", {sram_oe_n, sram_we_n, sram_dq_oe}, {1'b0, 1'b1, 1'b0});
    tick();
    chk("rd_c2_pins", {sram_oe_n, sram_dq_oe, a_ack}, {1'b0, 1'b0, 1'b0});
    tick();
    chk("rd_c3_ack", {sram_oe_n, a_ack}, {1'b1, 1'b1});
    chk("rd_c3_data", a_rdata, 32'hBEEF);
    a_req = 1'b0;
    tick();

    // 3: B byte-lane write 0x1234 be=10 over 0xAAAA, then read
    b_req = 1'b1; b_we = 1'b1; b_addr = 17'h00020; b_wdata = 16'h1234; b_be = 2'b10;
    tick();
    chk("be_c1_lanes", {sram_ub_n, sram_lb_n, sram_we_n}, {1'b0, 1'b1, 1'b0});
    tick(); tick();
    chk("be_c3_ack", {a_ack, b_ack}, 2'b01);
    b_req = 1'b0;
    tick();
    b_req = 1'b1; b_we = 1'b0; b_be = 2'b11;
    tick(); tick(); tick();
    chk("be_rd_ack", {a_ack, b_ack}, 2'b01);
    chk("be_rd_data", b_rdata, 32'h12AA);
    chk("be_a_rdata_kept", a_rdata, 32'hBEEF);
    b_req = 1'b0;
    tick();

    // 5: B drops req after the first ACCESS cycle
    b_req = 1'b1; b_addr = 17'h00010;
    tick();
    b_req = 1'b0;
    tick(); tick();
    chk("drop_ack", {b_ack, b_rdata}, {1'b1, 16'hBEEF});
    tick();
    chk("drop_c4", {b_ack, busy}, 2'b00);
    tick();
    chk("drop_c5_no_restart", {b_ack, busy, sram_oe_n}, 3'b001);

    // 2: simultaneous held requests straight after reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 17'h00010;
    b_req = 1'b1; b_we = 1'b0; b_addr = 17'h00020;
    for (int k = 0; k < 4; k++) begin
      tick(); tick(); tick();
`ifdef SRAM_ARB_FIXED_PRIO_EN
      chk("tie_grant", {a_ack, b_ack}, 2'b10);
`else
      chk("tie_grant", {a_ack, b_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
`endif
      tick();
    end
    a_req = 1'b0; b_req = 1'b0;
    tick(); tick(); tick(); tick();

    // 4: reset in the second ACCESS cycle of an A write
    a_req = 1'b1; a_we = 1'b1; a_addr = 17'h00040; a_wdata = 16'h5555;
    tick(); tick();
    chk("rstmid_c2_active", sram_we_n, 32'h0);
    reset = 1'b1;
    tick();
    chk("rstmid_strobes", {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe, busy, a_ack},
        7'b1111000);
    reset = 1'b0;
    b_req = 1'b1; b_we = 1'b0;
    tick();
    chk("rstmid_no_ack", {a_ack, b_ack}, 2'b00);
    tick(); tick();
    chk("rstmid_tie_a", {a_ack, b_ack}, 2'b10);
    a_req = 1'b0; b_req = 1'b0;
    tick(); tick();

    // 6: ACCESS_CYCLES=1 instance, back-to-back held A reads
    p_a_req = 1'b1;
    tick();
    chk("ac1_c1", {p_oe_n, p_a_ack, p_dq_oe}, 3'b000);
    tick();
    chk("ac1_c2_ack", {p_oe_n, p_a_ack}, 2'b11);
    chk("ac1_rdata", p_a_rdata, 32'h5A5A);
    tick();
    chk("ac1_c3_idle", {p_oe_n, p_a_ack, p_busy}, 3'b100);
    tick();
    chk("ac1_c4_next", {p_oe_n, p_a_ack}, 2'b00);
    tick();
    chk("ac1_c5_ack", p_a_ack, 32'h1);
    p_a_req = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
